// File: rtl/pll_reset_sequencer.sv
// Brings up a PLL from its reference clock: pulses RESETB, waits for a stable lock,
// holds the downstream reset, then watches for lock loss with bounded retries.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RESET_HOLD_CYCLES   = 256,
  parameter int LOSS_FILTER_CYCLES  = 4,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  output logic       pll_resetb,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count
);

  // state     | meaning
  // PLL_RST   | PLL held in reset for PLL_RST_CYCLES
  // WAIT_LOCK | PLL released, waiting for LOCK_STABLE_CYCLES of steady lock
  // RELEASE   | lock accepted, downstream reset still held
  // RUN       | downstream reset released, lock-loss filter active
  // FAULT     | retries exhausted, parked until reset
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, RELEASE, RUN, FAULT} state_t;

  localparam int CNT_MAX_A = (PLL_RST_CYCLES > RESET_HOLD_CYCLES) ? PLL_RST_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_MAX   = (LOCK_TIMEOUT_CYCLES > CNT_MAX_A) ? LOCK_TIMEOUT_CYCLES : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int FILT_MAX  = (LOCK_STABLE_CYCLES > LOSS_FILTER_CYCLES) ? LOCK_STABLE_CYCLES : LOSS_FILTER_CYCLES;
  localparam int FILT_W    = $clog2(FILT_MAX + 1);

  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_TOP   = CNT_W'(CNT_MAX);
  localparam logic [FILT_W-1:0] STABLE_N  = FILT_W'(LOCK_STABLE_CYCLES);
  localparam logic [FILT_W-1:0] LOSS_N    = FILT_W'(LOSS_FILTER_CYCLES);
  localparam logic [FILT_W-1:0] FILT_TOP  = FILT_W'(FILT_MAX);
  localparam logic [3:0]        MAX_N     = 4'(MAX_RETRIES);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx, cnt_inc;
  logic [FILT_W-1:0] filt, filt_nx, filt_inc;
  logic [3:0]        retry_nx, retry_inc;
  logic              sync1, locked_s;
  logic              fail;

  assign cnt_inc   = (cnt == CNT_TOP) ? cnt : cnt + 1'b1;
  assign filt_inc  = (filt == FILT_TOP) ? filt : filt + 1'b1;
  assign retry_inc = (retry_count == 4'hF) ? 4'hF : retry_count + 4'd1;

  // filt is the stability count in WAIT_LOCK and the loss count in RUN
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    filt_nx  = filt;
    retry_nx = retry_count;
    fail     = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) state_nx = WAIT_LOCK;
        else                 cnt_nx   = cnt_inc;
      end
      WAIT_LOCK: begin
        cnt_nx  = cnt_inc;
        filt_nx = locked_s ? filt_inc : '0;
        if (locked_s && filt_inc == STABLE_N) state_nx = RELEASE;
        else if (cnt == TO_LAST)              fail     = 1'b1;
      end
      RELEASE: begin
        if (!locked_s)              fail     = 1'b1;
        else if (cnt == HOLD_LAST)  state_nx = RUN;
        else                        cnt_nx   = cnt_inc;
      end
      RUN: begin
        filt_nx = locked_s ? '0 : filt_inc;
        if (!locked_s && filt_inc == LOSS_N) fail = 1'b1;
      end
      FAULT: state_nx = FAULT;
      default: state_nx = PLL_RST;
    endcase
    if (fail) begin
      retry_nx = retry_inc;
      state_nx = (retry_inc > MAX_N) ? FAULT : PLL_RST;
    end
    if (state_nx != state) begin
      cnt_nx  = '0;
      filt_nx = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PLL_RST;
      cnt         <= '0;
      filt        <= '0;
      retry_count <= 4'd0;
      sync1       <= 1'b0;
      locked_s    <= 1'b0;
      pll_resetb  <= 1'b0;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      filt        <= filt_nx;
      retry_count <= retry_nx;
      sync1       <= locked;
      locked_s    <= sync1;
      pll_resetb  <= (state_nx == WAIT_LOCK) || (state_nx == RELEASE) || (state_nx == RUN);
      sys_reset   <= (state_nx != RUN);
      ready       <= (state_nx == RUN);
      fault       <= (state_nx == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: phase/history reference model checked every cycle,
// directed bring-up scenarios with pinned literal timings, then randomized lock activity.
module tb_pll_reset_sequencer;

  localparam int P_RST = 4, P_STABLE = 8, P_TO = 32, P_HOLD = 6, P_LOSS = 3, P_MAX = 2;
  localparam int M_RST = 0, M_WAIT = 1, M_REL = 2, M_RUN = 3, M_FAULT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       locked = 1'b0;
  logic       pll_resetb, sys_reset, ready, fault;
  logic [3:0] retry_count;

  int n_checks = 0;
  int n_fail   = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(P_RST), .LOCK_STABLE_CYCLES(P_STABLE), .LOCK_TIMEOUT_CYCLES(P_TO),
    .RESET_HOLD_CYCLES(P_HOLD), .LOSS_FILTER_CYCLES(P_LOSS), .MAX_RETRIES(P_MAX)
  ) dut (
    .clk(clk), .reset(reset), .locked(locked), .pll_resetb(pll_resetb),
    .sys_reset(sys_reset), .ready(ready), .fault(fault), .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  // Reference model: a phase plus the list of synchronized lock samples seen during it.
  int m_phase = M_RST;
  bit m_hist[$];
  int m_retry = 0;
  bit m_s1 = 0, m_s2 = 0;
  bit m_valid = 0;
  int cyc = 0;
  int first_ready = -1, first_resetb = -1, first_fault = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  function automatic int trailing(input bit v);
    int n = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (m_hist[i] != v) break;
      n++;
    end
    return n;
  endfunction

  task automatic enter(input int ph);
    m_phase = ph;
    m_hist.delete();
  endtask

  task automatic attempt_failed();
    m_retry = (m_retry >= 15) ? 15 : m_retry + 1;
    enter((m_retry > P_MAX) ? M_FAULT : M_RST);
  endtask

  // Predicts the effect of the coming rising edge given the inputs now applied.
  task automatic model_step();
    bit s;
    if (reset) begin
      enter(M_RST);
      m_retry = 0; m_s1 = 0; m_s2 = 0; m_valid = 1; cyc = 0;
      first_ready = -1; first_resetb = -1; first_fault = -1;
      return;
    end
    if (!m_valid) return;
    cyc++;
    s = m_s2;
    m_s2 = m_s1;
    m_s1 = locked;
    if (m_phase == M_FAULT) return;
    m_hist.push_back(s);
    case (m_phase)
      M_RST:  if (m_hist.size() >= P_RST) enter(M_WAIT);
      M_WAIT: begin
        if (trailing(1'b1) >= P_STABLE) enter(M_REL);
        else if (m_hist.size() >= P_TO) attempt_failed();
      end
      M_REL: begin
        if (!s) attempt_failed();
        else if (m_hist.size() >= P_HOLD) enter(M_RUN);
      end
      M_RUN:  if (trailing(1'b0) >= P_LOSS) attempt_failed();
      default: ;
    endcase
  endtask

  // Single compare process: outputs after edge N are checked on the following falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("pll_resetb", {31'b0, pll_resetb},
          {31'b0, (m_phase == M_WAIT || m_phase == M_REL || m_phase == M_RUN)});
      chk("sys_reset", {31'b0, sys_reset}, {31'b0, (m_phase != M_RUN)});
      chk("ready", {31'b0, ready}, {31'b0, (m_phase == M_RUN)});
      chk("fault", {31'b0, fault}, {31'b0, (m_phase == M_FAULT)});
      chk("retry_count", {28'b0, retry_count}, m_retry);
      if (ready === 1'b1 && first_ready < 0) first_ready = cyc;
      if (pll_resetb === 1'b1 && first_resetb < 0) first_resetb = cyc;
      if (fault === 1'b1 && first_fault < 0) first_fault = cyc;
    end
    model_step();
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    locked = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  // One-cycle reset pulse with the post-reset outputs pinned literally.
  task automatic do_reset_check(input string tag);
    reset = 1'b1;
    locked = 1'b0;
    tick(1);
    chk({tag, "_pll_resetb"}, {31'b0, pll_resetb}, 0);
    chk({tag, "_sys_reset"}, {31'b0, sys_reset}, 1);
    chk({tag, "_ready"}, {31'b0, ready}, 0);
    chk({tag, "_fault"}, {31'b0, fault}, 0);
    chk({tag, "_retry"}, {28'b0, retry_count}, 0);
    reset = 1'b0;
  endtask

  task automatic nominal(input string tag);
    tick(10);
    locked = 1'b1;
    tick(40);
    chk({tag, "_resetb_rise_cycle"}, first_resetb, 4);
    chk({tag, "_ready_rise_cycle"}, first_ready, 26);
    chk({tag, "_retry"}, {28'b0, retry_count}, 0);
  endtask

  initial begin
    int r;
    tick(3);

    // Nominal bring-up
    do_reset();
    nominal("nominal");

    // RUN glitch filter: 2-cycle dip ignored, 3-cycle dip restarts the PLL
    locked = 1'b0; tick(2); locked = 1'b1;
    tick(10);
    chk("glitch2_ready", {31'b0, ready}, 1);
    locked = 1'b0; tick(3); locked = 1'b1;
    tick(3);
    chk("glitch3_sys_reset", {31'b0, sys_reset}, 1);
    chk("glitch3_pll_resetb", {31'b0, pll_resetb}, 0);
    chk("glitch3_retry", {28'b0, retry_count}, 1);
    tick(40);

    // Reset mid-RUN restarts the full sequence
    chk("relock_ready", {31'b0, ready}, 1);
    do_reset_check("rst_run");
    nominal("after_run_reset");

    // Lock chatter in WAIT_LOCK never qualifies and times out once
    do_reset();
    for (int i = 0; i < 8; i++) begin
      locked = (i % 2 == 0);
      tick(5);
    end
    locked = 1'b0;
    chk("chatter_retry", {28'b0, retry_count}, 1);
    chk("chatter_no_ready", first_ready, -1);

    // Lock drop during RELEASE hold
    do_reset();
    tick(10);
    locked = 1'b1;
    tick(12);
    locked = 1'b0; tick(1); locked = 1'b1;
    tick(8);
    chk("rel_drop_retry", {28'b0, retry_count}, 1);
    chk("rel_drop_no_ready", first_ready, -1);
    tick(40);

    // Never locks: three timeouts then FAULT, held indefinitely
    do_reset();
    tick(120);
    chk("nolock_fault_cycle", first_fault, 108);
    chk("nolock_retry", {28'b0, retry_count}, 3);
    tick(50);
    chk("nolock_fault_held", {31'b0, fault}, 1);
    chk("nolock_sys_reset", {31'b0, sys_reset}, 1);

    // Reset out of FAULT
    do_reset_check("rst_fault");
    nominal("after_fault_reset");

    // Randomized lock activity with occasional resets
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end else if (r < 65) begin
        locked = 1'b1;
        tick($urandom_range(1, 25));
      end else if (r < 90) begin
        locked = 1'b0;
        tick($urandom_range(1, 4));
      end else begin
        locked = 1'b0;
        tick($urandom_range(5, 40));
      end
    end
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
